kmeans_dist_pipe: RTL

- Parametrised, pipelined K-means distance stage that generalises the fixed 8-center, single-cycle distance block.
- Per accepted point it computes the squared Euclidean distance to NUM_CENTER centers, then the nearest center (argmin) and its distance.
- Valid/ready streaming with full backpressure. Sits between the point-memory reader and the label/accumulate stage.

---
 rtl/kmeans_dist_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/kmeans_dist_pipe.sv
// Pipelined K-means distance stage: per-center distance, argmin, and per-pass result count.
// Define KMEANS_L1_DIST_EN to build with Manhattan (L1) distance instead of squared Euclidean.

module kmeans_dist_lane #(
  parameter int WIDTH  = 16,
  parameter int DIST_W = 2*WIDTH+1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [WIDTH-1:0]  i_px,
  input  logic [WIDTH-1:0]  i_py,
  input  logic [WIDTH-1:0]  i_cx,
  input  logic [WIDTH-1:0]  i_cy,
  output logic [DIST_W-1:0] o_dist
);
`ifdef KMEANS_L1_DIST_EN
  localparam int SQ_W = WIDTH;
`else
  localparam int SQ_W = 2*WIDTH;
`endif

  logic signed [WIDTH:0] r_dx, r_dy;
  logic [WIDTH:0]        w_nx, w_ny;
  logic [WIDTH-1:0]      w_ax, w_ay;
  logic [SQ_W-1:0]       r_sx, r_sy;
  logic [DIST_W-1:0]     r_dist;

  // |d| never exceeds 2^WIDTH-1, so the low WIDTH bits of the negation suffice
  assign w_nx = -r_dx;
  assign w_ny = -r_dy;
  assign w_ax = r_dx[WIDTH] ? w_nx[WIDTH-1:0] : r_dx[WIDTH-1:0];
  assign w_ay = r_dy[WIDTH] ? w_ny[WIDTH-1:0] : r_dy[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dx   <= '0;
      r_dy   <= '0;
      r_sx   <= '0;
      r_sy   <= '0;
      r_dist <= '0;
    end else if (i_en) begin
      r_dx <= $signed({1'b0, i_px}) - $signed({1'b0, i_cx});
      r_dy <= $signed({1'b0, i_py}) - $signed({1'b0, i_cy});
`ifdef KMEANS_L1_DIST_EN
      r_sx   <= w_ax;
      r_sy   <= w_ay;
      r_dist <= DIST_W'({1'b0, r_sx} + {1'b0, r_sy});
`else
      r_sx   <= {{WIDTH{1'b0}}, w_ax} * {{WIDTH{1'b0}}, w_ax};
      r_sy   <= {{WIDTH{1'b0}}, w_ay} * {{WIDTH{1'b0}}, w_ay};
      r_dist <= DIST_W'({1'b0, r_sx}) + DIST_W'({1'b0, r_sy});
`endif
    end
  end

  assign o_dist = r_dist;
endmodule

module kmeans_dist_pipe #(
  parameter int WIDTH          = 16,
  parameter int NUM_CENTER     = 8,
  parameter int LOG_NUM_CENTER = 3,
  parameter int DIST_W         = 2*WIDTH+1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [WIDTH-1:0]               pointx,
  input  logic [WIDTH-1:0]               pointy,
  input  logic [NUM_CENTER*WIDTH-1:0]    centerx_flat,
  input  logic [NUM_CENTER*WIDTH-1:0]    centery_flat,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [NUM_CENTER*DIST_W-1:0]   dist_flat,
  output logic [LOG_NUM_CENTER-1:0]      min_label,
  output logic [DIST_W-1:0]              min_dist,
  output logic [15:0]                    pt_count
);
  localparam int STAGES = 4;

  logic                              w_stall, w_en, w_in_fire, w_out_fire;
  logic [STAGES:1]                   r_vld_pipe, r_last_pipe;
  logic [NUM_CENTER-1:0][DIST_W-1:0] w_dist;
  logic [NUM_CENTER*DIST_W-1:0]      r_dist_flat;
  logic [LOG_NUM_CENTER-1:0]         w_min_label, r_min_label;
  logic [DIST_W-1:0]                 w_min_dist, r_min_dist;
  logic [15:0]                       r_pt_count;

  // The whole pipe freezes on a blocked output, so one enable drives every stage
  assign w_stall    = r_vld_pipe[STAGES] & ~out_ready;
  assign w_en       = ~w_stall;
  assign in_ready   = w_en;
  assign w_in_fire  = in_valid & w_en;
  assign w_out_fire = r_vld_pipe[STAGES] & out_ready;

  genvar g;
  generate
    for (g = 0; g < NUM_CENTER; g++) begin : g_lane
      kmeans_dist_lane #(.WIDTH(WIDTH), .DIST_W(DIST_W)) u_lane (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_en),
        .i_px   (pointx),
        .i_py   (pointy),
        .i_cx   (centerx_flat[g*WIDTH +: WIDTH]),
        .i_cy   (centery_flat[g*WIDTH +: WIDTH]),
        .o_dist (w_dist[g])
      );
    end
  endgenerate

  // Strict less-than keeps the lowest index on ties
  always_comb begin
    w_min_label = '0;
    w_min_dist  = w_dist[0];
    for (int i = 1; i < NUM_CENTER; i++) begin
      if (w_dist[i] < w_min_dist) begin
        w_min_dist  = w_dist[i];
        w_min_label = LOG_NUM_CENTER'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else if (w_en) begin
      r_vld_pipe  <= {r_vld_pipe[STAGES-1:1], w_in_fire};
      r_last_pipe <= {r_last_pipe[STAGES-1:1], in_last};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dist_flat <= '0;
      r_min_label <= '0;
      r_min_dist  <= '0;
    end else if (w_en && r_vld_pipe[STAGES-1]) begin
      r_dist_flat <= w_dist;
      r_min_label <= w_min_label;
      r_min_dist  <= w_min_dist;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             r_pt_count <= '0;
    else if (w_out_fire) r_pt_count <= r_last_pipe[STAGES] ? 16'd0 : r_pt_count + 16'd1;
  end

  assign out_valid = r_vld_pipe[STAGES];
  assign out_last  = r_last_pipe[STAGES];
  assign dist_flat = r_dist_flat;
  assign min_label = r_min_label;
  assign min_dist  = r_min_dist;
  assign pt_count  = r_pt_count;
endmodule
